// File: rtl/dallanma_ongorucu_pkg.sv
// ----------------------------------------------------------------------------
// dallanma_ongorucu_pkg
// Shared definitions for the gshare branch predictor slice.
//   - Default table sizing (SATIR_BIT_VARSAYILAN, GHR_BIT_VARSAYILAN)
//   - 2-bit saturating counter encoding (sayac_e)
//   - sayacGuncelle: one training step of a saturating counter
//   - sayacAtlar: whether a counter state means "predict taken"
// No ports; imported by the interface, the BTB and the top module.
// ----------------------------------------------------------------------------
package dallanma_ongorucu_pkg;

  localparam int SATIR_BIT_VARSAYILAN = 6;
  localparam int GHR_BIT_VARSAYILAN   = 6;
  localparam int PS_GENISLIK          = 32;

  // Counter states, ordered so that plain +1/-1 walks between them and the
  // MSB alone decides the taken/not-taken prediction.
  typedef enum logic [1:0] {
    GUCLU_ATLAMAZ = 2'b00,
    ZAYIF_ATLAMAZ = 2'b01,
    ZAYIF_ATLAR   = 2'b10,
    GUCLU_ATLAR   = 2'b11
  } sayac_e;

  // One training step: a taken outcome climbs towards GUCLU_ATLAR, a
  // not-taken outcome falls towards GUCLU_ATLAMAZ, and both ends stick.
  function automatic sayac_e sayacGuncelle(input sayac_e mevcut, input logic atladi);
    sayac_e sonraki;
    sonraki = mevcut;
    if (atladi) begin
      if (mevcut != GUCLU_ATLAR) begin
        sonraki = sayac_e'(mevcut + 2'b01);
      end
    end else begin
      if (mevcut != GUCLU_ATLAMAZ) begin
        sonraki = sayac_e'(mevcut - 2'b01);
      end
    end
    return sonraki;
  endfunction

  // Both "taken" states share a set MSB.
  function automatic logic sayacAtlar(input sayac_e durum);
    return durum[1];
  endfunction

endpackage

// File: rtl/dallanma_ongorucu_if.sv
// ----------------------------------------------------------------------------
// dallanma_ongorucu_if
// Bundles the fetch-side prediction request/response and the resolution-side
// training signals of the branch predictor.
//   ps_i, ps_gecerli_i            fetch PC and its valid flag
//   ongoru_atla_o                 predicted taken
//   ongoru_hedef_o                predicted target (0 when not taken)
//   ongoru_ghr_o                  GHR snapshot used for the prediction
//   guncelle_gecerli_i            a resolved branch is presented this cycle
//   guncelle_atladi_i             actual outcome (1 = taken)
//   guncelle_ps_i                 PC of the resolved branch
//   guncelle_hedef_adresi_i       resolved target
//   guncelle_ghr_i                GHR snapshot that travelled with the branch
//   dallanma_hata_i               misprediction flag
// Modports: slave = the predictor, master = the pipeline driving it.
// ----------------------------------------------------------------------------
interface dallanma_ongorucu_if
  import dallanma_ongorucu_pkg::*;
#(
  parameter int GHR_BIT = GHR_BIT_VARSAYILAN
) ();

  logic [PS_GENISLIK-1:0] ps_i;
  logic                   ps_gecerli_i;
  logic                   ongoru_atla_o;
  logic [PS_GENISLIK-1:0] ongoru_hedef_o;
  logic [GHR_BIT-1:0]     ongoru_ghr_o;
  logic                   guncelle_gecerli_i;
  logic                   guncelle_atladi_i;
  logic [PS_GENISLIK-1:0] guncelle_ps_i;
  logic [PS_GENISLIK-1:0] guncelle_hedef_adresi_i;
  logic [GHR_BIT-1:0]     guncelle_ghr_i;
  logic                   dallanma_hata_i;

  modport slave (
    input  ps_i,
    input  ps_gecerli_i,
    output ongoru_atla_o,
    output ongoru_hedef_o,
    output ongoru_ghr_o,
    input  guncelle_gecerli_i,
    input  guncelle_atladi_i,
    input  guncelle_ps_i,
    input  guncelle_hedef_adresi_i,
    input  guncelle_ghr_i,
    input  dallanma_hata_i
  );

  modport master (
    output ps_i,
    output ps_gecerli_i,
    input  ongoru_atla_o,
    input  ongoru_hedef_o,
    input  ongoru_ghr_o,
    output guncelle_gecerli_i,
    output guncelle_atladi_i,
    output guncelle_ps_i,
    output guncelle_hedef_adresi_i,
    output guncelle_ghr_i,
    output dallanma_hata_i
  );

endinterface

// File: rtl/dallanma_ongorucu_hedef_tablosu.sv
// ----------------------------------------------------------------------------
// dallanma_hedef_tablosu
// Direct-mapped branch target buffer: per-row valid bit, tag and target.
//   clk_i, rst_i       clock, synchronous active-low reset (clears valid bits)
//   oku_satir_i        row addressed by the fetch PC
//   oku_etiket_i       tag of the fetch PC
//   isabet_o           row is valid and its tag matches
//   hedef_o            stored target of the addressed row
//   yaz_i              write strobe (taken branch resolved)
//   yaz_satir_i        row of the resolved branch
//   yaz_etiket_i       tag of the resolved branch
//   yaz_hedef_i        resolved target to store
// Reads are combinational from the registered arrays, so a write in the same
// cycle as a read of that row becomes visible only from the next cycle.
// ----------------------------------------------------------------------------
module dallanma_hedef_tablosu
  import dallanma_ongorucu_pkg::*;
#(
  parameter int SATIR_BIT  = SATIR_BIT_VARSAYILAN,
  parameter int ETIKET_BIT = PS_GENISLIK - SATIR_BIT_VARSAYILAN - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [SATIR_BIT-1:0]   oku_satir_i,
  input  logic [ETIKET_BIT-1:0]  oku_etiket_i,
  output logic                   isabet_o,
  output logic [PS_GENISLIK-1:0] hedef_o,
  input  logic                   yaz_i,
  input  logic [SATIR_BIT-1:0]   yaz_satir_i,
  input  logic [ETIKET_BIT-1:0]  yaz_etiket_i,
  input  logic [PS_GENISLIK-1:0] yaz_hedef_i
);

  localparam int SATIR_SAYISI = 1 << SATIR_BIT;

  logic                   gecerli_q [SATIR_SAYISI];
  logic                   gecerli_d [SATIR_SAYISI];
  logic [ETIKET_BIT-1:0]  etiket_q  [SATIR_SAYISI];
  logic [PS_GENISLIK-1:0] hedef_q   [SATIR_SAYISI];

  // A write only ever sets a valid bit; nothing but reset clears one, so an
  // entry stays usable until it is overwritten by another taken branch.
  always_comb begin
    gecerli_d = gecerli_q;
    if (yaz_i) begin
      gecerli_d[yaz_satir_i] = 1'b1;
    end
  end

  // Valid bits are the only BTB state that needs a reset: with all of them
  // cleared the tag/target contents are never looked at.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SATIR_SAYISI; i++) begin
        gecerli_q[i] <= 1'b0;
      end
    end else begin
      gecerli_q <= gecerli_d;
    end
  end

  // Tag and target storage; a write arriving during reset is dropped so the
  // whole update disappears, not just its valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i && yaz_i) begin
      etiket_q[yaz_satir_i] <= yaz_etiket_i;
      hedef_q[yaz_satir_i]  <= yaz_hedef_i;
    end
  end

  // Hit needs both a valid row and a full tag match, so two PCs sharing a
  // row never hand each other's target out.
  always_comb begin
    isabet_o = gecerli_q[oku_satir_i] && (etiket_q[oku_satir_i] == oku_etiket_i);
    hedef_o  = hedef_q[oku_satir_i];
  end

endmodule

// File: rtl/dallanma_ongorucu.sv
// ----------------------------------------------------------------------------
// dallanma_ongorucu
// Gshare conditional-branch predictor with a branch target buffer.
//   clk_i   clock; every state update happens on the rising edge
//   rst_i   synchronous, active-low reset
//   bus     dallanma_ongorucu_if.slave: fetch request/prediction and
//           resolution-stage training signals
// Fetch side: the PC row XOR the live GHR picks a 2-bit counter; the
// prediction is "taken" only when the counter says so and the BTB holds a
// matching entry for the PC. The GHR used is handed out with the prediction.
// Resolution side: the returned GHR snapshot (never the live one) selects the
// counter to train, and the history is rebuilt from that snapshot so any
// wrong-path history is thrown away. hataSayaci_q counts reported
// mispredictions for debug only.
// ----------------------------------------------------------------------------
module dallanma_ongorucu
  import dallanma_ongorucu_pkg::*;
#(
  parameter int SATIR_BIT = SATIR_BIT_VARSAYILAN,
  parameter int GHR_BIT   = GHR_BIT_VARSAYILAN
) (
  input logic                clk_i,
  input logic                rst_i,
  dallanma_ongorucu_if.slave bus
);

  localparam int SATIR_SAYISI = 1 << SATIR_BIT;
  localparam int ETIKET_BIT   = PS_GENISLIK - SATIR_BIT - 2;

  sayac_e                 phtTablo_q [SATIR_SAYISI];
  sayac_e                 phtTablo_d [SATIR_SAYISI];
  logic [GHR_BIT-1:0]     ghr_q;
  logic [GHR_BIT-1:0]     ghr_d;
  logic [PS_GENISLIK-1:0] hataSayaci_q;
  logic [PS_GENISLIK-1:0] hataSayaci_d;

  logic [SATIR_BIT-1:0]   okumaSatir;
  logic [SATIR_BIT-1:0]   okumaPhtIdx;
  logic [ETIKET_BIT-1:0]  okumaEtiket;
  logic [SATIR_BIT-1:0]   yazmaSatir;
  logic [SATIR_BIT-1:0]   yazmaPhtIdx;
  logic [ETIKET_BIT-1:0]  yazmaEtiket;
  logic                   tahminGecerli;
  logic                   btbYaz;
  logic                   btbIsabet;
  logic [PS_GENISLIK-1:0] btbHedef;
  logic                   tahminAtla;
  logic                   unusedBitler;

  // Index/tag split of both PCs. The low two PC bits never take part. The
  // history is zero-extended on the left before the XOR, which is why the
  // GHR may not be longer than the row index.
  always_comb begin
    okumaSatir  = bus.ps_i[SATIR_BIT+1:2];
    okumaEtiket = bus.ps_i[PS_GENISLIK-1:SATIR_BIT+2];
    okumaPhtIdx = okumaSatir ^ SATIR_BIT'(ghr_q);
    yazmaSatir  = bus.guncelle_ps_i[SATIR_BIT+1:2];
    yazmaEtiket = bus.guncelle_ps_i[PS_GENISLIK-1:SATIR_BIT+2];
    yazmaPhtIdx = yazmaSatir ^ SATIR_BIT'(bus.guncelle_ghr_i);
  end

  // Bits that the indexing scheme deliberately discards; folded together so
  // they are visibly accounted for.
  assign unusedBitler = ^{bus.ps_i[1:0], bus.guncelle_ps_i[1:0],
                          bus.guncelle_ghr_i[GHR_BIT-1]};

  // Only a taken branch teaches the BTB anything; a not-taken outcome has no
  // useful target and must not evict a good entry.
  assign btbYaz = bus.guncelle_gecerli_i & bus.guncelle_atladi_i;

  dallanma_hedef_tablosu #(
    .SATIR_BIT  (SATIR_BIT),
    .ETIKET_BIT (ETIKET_BIT)
  ) u_hedefTablosu (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .oku_satir_i  (okumaSatir),
    .oku_etiket_i (okumaEtiket),
    .isabet_o     (btbIsabet),
    .hedef_o      (btbHedef),
    .yaz_i        (btbYaz),
    .yaz_satir_i  (yazmaSatir),
    .yaz_etiket_i (yazmaEtiket),
    .yaz_hedef_i  (bus.guncelle_hedef_adresi_i)
  );

  // Prediction path, purely combinational from registered state. While reset
  // is asserted or no PC is offered every output is forced to zero, so the
  // fetch stage never sees stale tables. There is no bypass from a
  // same-cycle update: the prediction uses the pre-update counter.
  always_comb begin
    tahminGecerli      = rst_i & bus.ps_gecerli_i;
    tahminAtla         = tahminGecerli & btbIsabet & sayacAtlar(phtTablo_q[okumaPhtIdx]);
    bus.ongoru_atla_o  = tahminAtla;
    bus.ongoru_hedef_o = tahminAtla ? btbHedef : '0;
    bus.ongoru_ghr_o   = tahminGecerli ? ghr_q : '0;
  end

  // Training path. Everything keys off guncelle_gecerli_i, so stray values
  // on the other update inputs are harmless. The misprediction flag does not
  // alter training; the counter it feeds is purely observational.
  always_comb begin
    phtTablo_d   = phtTablo_q;
    ghr_d        = ghr_q;
    hataSayaci_d = hataSayaci_q;
    if (bus.guncelle_gecerli_i) begin
      phtTablo_d[yazmaPhtIdx] = sayacGuncelle(phtTablo_q[yazmaPhtIdx], bus.guncelle_atladi_i);
      ghr_d = {bus.guncelle_ghr_i[GHR_BIT-2:0], bus.guncelle_atladi_i};
      if (bus.dallanma_hata_i) begin
        hataSayaci_d = hataSayaci_q + 32'd1;
      end
    end
  end

  // State registers. Reset wins over any update in the same cycle, leaves
  // every counter weakly not-taken and clears the history and debug count.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SATIR_SAYISI; i++) begin
        phtTablo_q[i] <= ZAYIF_ATLAMAZ;
      end
      ghr_q        <= '0;
      hataSayaci_q <= '0;
    end else begin
      phtTablo_q   <= phtTablo_d;
      ghr_q        <= ghr_d;
      hataSayaci_q <= hataSayaci_d;
    end
  end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// ----------------------------------------------------------------------------
// tb_dallanma_ongorucu
// Self-checking bench for dallanma_ongorucu: directed scenarios followed by
// randomized traffic, all checked against a behavioural model that keeps the
// tables as plain integer arrays.
// ----------------------------------------------------------------------------
module tb_dallanma_ongorucu;

  localparam int SATIR_BIT = 6;
  localparam int GHR_BIT   = 6;
  localparam int ROWS      = 64;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  int unsigned modelPht    [ROWS];
  bit          modelValid  [ROWS];
  int unsigned modelTag    [ROWS];
  int unsigned modelTarget [ROWS];
  int unsigned modelGhr  = 0;
  int unsigned modelHata = 0;
  bit          modelInit = 1'b0;

  dallanma_ongorucu_if #(.GHR_BIT(GHR_BIT)) bus ();

  dallanma_ongorucu #(
    .SATIR_BIT (SATIR_BIT),
    .GHR_BIT   (GHR_BIT)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", name, observed, expected);
    end
  endtask

  function automatic int unsigned rowOf(input logic [31:0] pc);
    int unsigned u;
    u = pc;
    return (u / 4) % ROWS;
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    int unsigned u;
    u = pc;
    return u / (4 * ROWS);
  endfunction

  // What the predictor should say for this PC given the model tables.
  function automatic int unsigned expectedTaken(input bit r, input logic [31:0] pc, input bit pv);
    int unsigned row;
    if (!r || !pv) return 0;
    row = rowOf(pc);
    if (!modelValid[row] || modelTag[row] != tagOf(pc)) return 0;
    return (modelPht[row ^ modelGhr] >= 2) ? 1 : 0;
  endfunction

  // Model state transition for one clock edge.
  task automatic modelUpdate(input bit r, input bit gv, input bit gt, input logic [31:0] gps,
                             input logic [31:0] gtgt, input int unsigned gghr, input bit hata);
    int unsigned p;
    int unsigned row;
    if (!r) begin
      for (int i = 0; i < ROWS; i++) begin
        modelPht[i]   = 1;
        modelValid[i] = 1'b0;
      end
      modelGhr  = 0;
      modelHata = 0;
      modelInit = 1'b1;
    end else if (gv) begin
      row = rowOf(gps);
      p   = row ^ gghr;
      if (gt) begin
        if (modelPht[p] < 3) modelPht[p] = modelPht[p] + 1;
        modelValid[row]  = 1'b1;
        modelTag[row]    = tagOf(gps);
        modelTarget[row] = gtgt;
      end else begin
        if (modelPht[p] > 0) modelPht[p] = modelPht[p] - 1;
      end
      modelGhr = (gghr * 2 + (gt ? 1 : 0)) % ROWS;
      if (hata) modelHata = modelHata + 1;
    end
  endtask

  // Drives one cycle of inputs, checks outputs against the model mid-cycle,
  // then advances the model across the clock edge.
  task automatic applyStimulus(input string name, input bit r, input logic [31:0] ps,
                               input bit pv, input bit gv, input bit gt,
                               input logic [31:0] gps, input logic [31:0] gtgt,
                               input int unsigned gghr, input bit hata);
    int unsigned expTaken;
    int unsigned expTarget;
    int unsigned expGhr;
    rst_i                       = r;
    bus.ps_i                    = ps;
    bus.ps_gecerli_i            = pv;
    bus.guncelle_gecerli_i      = gv;
    bus.guncelle_atladi_i       = gt;
    bus.guncelle_ps_i           = gps;
    bus.guncelle_hedef_adresi_i = gtgt;
    bus.guncelle_ghr_i          = gghr[5:0];
    bus.dallanma_hata_i         = hata;
    @(negedge clk_i);
    expTaken  = expectedTaken(r, ps, pv);
    expTarget = (expTaken != 0) ? modelTarget[rowOf(ps)] : 0;
    expGhr    = (r && pv) ? modelGhr : 0;
    checkOutput({name, "_atla"}, {31'd0, bus.ongoru_atla_o}, expTaken);
    checkOutput({name, "_hedef"}, bus.ongoru_hedef_o, expTarget);
    checkOutput({name, "_ghr"}, {26'd0, bus.ongoru_ghr_o}, expGhr);
    if (modelInit) begin
      checkOutput({name, "_hata"}, dut.hataSayaci_q, modelHata);
    end
    @(posedge clk_i);
    modelUpdate(r, gv, gt, gps, gtgt, gghr, hata);
    #1;
  endtask

  // Prediction-only cycle checked against hand-derived constants. The other
  // update inputs carry random junk with the valid flag low.
  task automatic expectPredict(input string name, input logic [31:0] ps,
                               input logic [31:0] expTaken, input logic [31:0] expTarget,
                               input logic [31:0] expGhr);
    rst_i                       = 1'b1;
    bus.ps_i                    = ps;
    bus.ps_gecerli_i            = 1'b1;
    bus.guncelle_gecerli_i      = 1'b0;
    bus.guncelle_atladi_i       = 1'($urandom_range(0, 1));
    bus.guncelle_ps_i           = $urandom;
    bus.guncelle_hedef_adresi_i = $urandom;
    bus.guncelle_ghr_i          = 6'($urandom_range(0, 63));
    bus.dallanma_hata_i         = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    checkOutput({name, "_atla"}, {31'd0, bus.ongoru_atla_o}, expTaken);
    checkOutput({name, "_hedef"}, bus.ongoru_hedef_o, expTarget);
    checkOutput({name, "_ghr"}, {26'd0, bus.ongoru_ghr_o}, expGhr);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] randPc();
    int unsigned u;
    u = ($urandom_range(1, 2) * 256) + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3);
    return u;
  endfunction

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    for (int i = 0; i < ROWS; i++) begin
      modelPht[i]    = 1;
      modelValid[i]  = 1'b0;
      modelTag[i]    = 0;
      modelTarget[i] = 0;
    end

    applyStimulus("rst0", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus("rst1", 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    expectPredict("reset", 32'h100, 0, 0, 0);

    applyStimulus("trainA", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h80, 0, 1'b1);
    applyStimulus("trainB", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h80, 0, 1'b0);
    expectPredict("train_fresh", 32'h100, 0, 0, 1);
    applyStimulus("trainC", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 0, 1'b0);
    expectPredict("train_hit", 32'h100, 1, 32'h80, 0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus("satT", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h108, 32'h400, 0, 1'b0);
    end
    applyStimulus("satN1", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 0, 1'b0);
    expectPredict("sat_10", 32'h108, 1, 32'h400, 0);
    applyStimulus("satN2", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 0, 1'b0);
    expectPredict("sat_01", 32'h108, 0, 0, 0);

    expectPredict("alias_own", 32'h100, 1, 32'h80, 0);
    expectPredict("alias_miss", 32'h200, 0, 0, 0);

    applyStimulus("scRst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus("scA", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h500, 0, 1'b0);
    applyStimulus("scB", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h304, 32'h600, 63, 1'b0);
    applyStimulus("same_cycle", 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 32'h300, 32'h500, 63, 1'b0);
    expectPredict("same_next", 32'h300, 1, 32'h500, 63);

    applyStimulus("midRst", 1'b0, 32'h300, 1'b1, 1'b1, 1'b1, 32'h300, 32'h500, 63, 1'b1);
    expectPredict("rst_mid_a", 32'h300, 0, 0, 0);
    expectPredict("rst_mid_b", 32'h100, 0, 0, 0);
    checkOutput("rst_mid_hata", dut.hataSayaci_q, 0);

    for (int n = 0; n < 500; n++) begin
      bit r;
      bit pv;
      bit gv;
      bit gt;
      bit hata;
      int unsigned gghr;
      r    = ($urandom_range(0, 99) != 0);
      pv   = ($urandom_range(0, 4) != 0);
      gv   = ($urandom_range(0, 4) < 3);
      gt   = 1'($urandom_range(0, 1));
      hata = 1'($urandom_range(0, 1));
      gghr = ($urandom_range(0, 1) != 0) ? modelGhr : $urandom_range(0, 63);
      applyStimulus("rand", r, randPc(), pv, gv, gt, randPc(), $urandom, gghr, hata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
